sound_mix: RTL and testbench
============================

# sound_mix

Parametrised multi-channel square-wave sound generator with a first-order sigma-delta 1-bit output, for the MIO CPLD. It replaces the single-channel PWM/sigma-delta DAC. Each channel holds a half-period and a level; enabled channels are summed and the sum drives one audio pin through an accumulator-carry modulator. The CPU writes channel and control registers over the local 8-bit bus with a level-sensitive write strobe.

## Interface
- `CHANNELS`, default 2: number of tone channels, 1..3.
- `ADDR_W`, default 3: register address width; must satisfy 2*CHANNELS+1 <= 2^ADDR_W.
- `PRESCALE`, default 64: clk cycles per tone tick, >= 1.

- `clk` in 1: system clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr` in ADDR_W: register select.
- `data_in` in 8: write data.
- `wr` in 1: write strobe, sampled each posedge; a write occurs on every cycle it is high.
- `snd` in/out: out 1: sigma-delta audio bit.

## Operation
- Register map:
  - addr 2c: PERIOD[c], 8-bit half-period in ticks.
  - addr 2c+1: LEVEL[c], 8-bit amplitude.
  - addr 2*CHANNELS: CTL. Bits [CHANNELS-1:0] are the channel enable mask; bit 7 is the noise select (see Configuration).
  - Other addresses: write ignored.
- Prescaler: counter 0..PRESCALE-1; `tick` is high for one cycle when it equals PRESCALE-1, then it wraps to 0. PRESCALE=1 gives tick every cycle.
- Channel c, when enabled, with P = PERIOD[c]:
  - P != 0, on tick: if cnt==0, then cnt<=P-1 and phase<=~phase; else cnt<=cnt-1. Phase toggles every P ticks; full period is 2P ticks.
  - P == 0: phase forced to 1 and cnt held at 0, giving DC at LEVEL (direct DAC mode).
  - Writing PERIOD does not touch cnt. The new value applies at the next reload.
- Disabled channel: cnt<=0, phase<=0, contribution 0. On re-enable it starts deterministically, toggling at the first tick.
- Contribution: phase ? LEVEL[c] : 0.
- Mix: MW = 8 + clog2(CHANNELS), minimum 9. `mix` is the registered zero-extended sum of all contributions; it cannot overflow.
- Modulator: acc is MW+1 bits. acc <= {1'b0, acc[MW-1:0]} + mix. `snd` = acc[MW], registered.
- Output density: ones density = mix / 2^MW, exact over any 2^MW cycles of constant mix.
- Write and tick in the same cycle: the tone logic uses the old register value; the written value is visible from the next cycle.

## Timing
- Reset values: all PERIOD, LEVEL, CTL = 0; cnt, phase, prescaler, mix, acc = 0; `snd` = 0; LFSR = 16'hACE1.
- Reset effect is immediate on `rst_n` falling, including mid-tone. Operation resumes on the first posedge after release, with the prescaler restarting at 0.
- Latency, write to `mix`: a write at edge N changes phase or contribution at edge N+1 and `mix` at edge N+2. The earliest `snd` effect is edge N+3.
- Tick to phase change: same edge as tick.
- No back-pressure. Writes always complete in one cycle.

## Configuration
- `SOUND_NOISE_EN` defined:
  - Adds a 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
  - When CTL[7]=1 and channel 0 is enabled with PERIOD[0] != 0, each channel-0 reload event steps the LFSR, and phase[0] = LFSR bit 0 instead of toggling.
  - With CTL[7]=0 the LFSR holds its value.
- `SOUND_NOISE_EN` undefined:
  - No LFSR logic.
  - CTL[7] is stored but has no effect; channel 0 is a plain tone.

## Test plan
- Reset: hold `rst_n` low 10 cycles, release, no writes → `snd` = 0 for 2000 cycles.
- DC: CHANNELS=2; write PERIOD0=0, LEVEL0=128, CTL=0x01 → exactly 128 ones in every 512-cycle window after settling.
- Full scale: both channels P=0, LEVEL=255, CTL=0x03 → 510 ones per 512 cycles. Then set CTL=0x00 → `snd` = 0 from edge N+3 onward.
- Tone: PRESCALE=1, PERIOD0=4, LEVEL0=255, CTL=0x01 → phase0 toggles every 4 cycles. Write PERIOD0=8 mid-count → the current half-period finishes at 4, then subsequent half-periods are 8.
- Async reset mid-tone: drop `rst_n` between edges → `snd`, mix and acc are 0 immediately. After release, PERIOD/LEVEL/CTL read back 0 (no output).
- Noise (`SOUND_NOISE_EN`): PRESCALE=1, PERIOD0=1, LEVEL0=255, CTL=0x81 → phase0 follows LFSR bit 0 from seed 16'hACE1. The sequence repeats after exactly 65535 steps.

Source files
------------

// File: rtl/sound_mix.sv
// Multi-channel square-wave tone mixer driving a 1-bit first-order sigma-delta output.
// Optional LFSR noise on channel 0 when SOUND_NOISE_EN is defined.
module sound_mix #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 3,
  parameter int PRESCALE = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  input  logic              wr,
  output logic              snd
);

  localparam int MW = (8 + $clog2(CHANNELS) < 9) ? 9 : 8 + $clog2(CHANNELS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [ADDR_W-1:0] CTL_ADDR = ADDR_W'(2 * CHANNELS);

  logic [7:0]          period  [CHANNELS];
  logic [7:0]          level   [CHANNELS];
  logic [7:0]          ctl;
  logic [PW-1:0]       pre;
  logic                tick;
  logic [7:0]          cnt     [CHANNELS];
  logic [7:0]          cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] phase;
  logic [CHANNELS-1:0] phase_d;
  logic [CHANNELS-1:0] reload;
  logic [7:0]          contrib [CHANNELS];
  logic [MW-1:0]       mix;
  logic [MW-1:0]       mix_d;
  logic [MW:0]         acc;
  logic                unused_ctl;

  // Upper CTL bits are storage only unless the noise option consumes bit 7.
  assign unused_ctl = ^ctl[7:CHANNELS];

  assign tick = (pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        period[c] <= 8'd0;
        level[c]  <= 8'd0;
      end
      ctl <= 8'd0;
    end else if (wr) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (addr == ADDR_W'(2 * c))     period[c] <= data_in;
        if (addr == ADDR_W'(2 * c + 1)) level[c]  <= data_in;
      end
      if (addr == CTL_ADDR) ctl <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre <= '0;
    else        pre <= tick ? '0 : pre + 1'b1;
  end

  always_comb begin
    reload = '0;
    for (int c = 0; c < CHANNELS; c++)
      reload[c] = ctl[c] && (period[c] != 8'd0) && tick && (cnt[c] == 8'd0);
  end

`ifdef SOUND_NOISE_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_nx;
  logic        noise_step;

  assign lfsr_nx    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign noise_step = ctl[7] && reload[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          lfsr <= 16'hACE1;
    else if (noise_step) lfsr <= lfsr_nx;
  end
`endif

  always_comb begin
    cnt_d   = cnt;
    phase_d = phase;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!ctl[c]) begin
        cnt_d[c]   = 8'd0;
        phase_d[c] = 1'b0;
      end else if (period[c] == 8'd0) begin
        cnt_d[c]   = 8'd0;
        phase_d[c] = 1'b1;
      end else if (tick) begin
        if (reload[c]) begin
          cnt_d[c]   = period[c] - 8'd1;
          phase_d[c] = ~phase[c];
        end else begin
          cnt_d[c] = cnt[c] - 8'd1;
        end
      end
    end
`ifdef SOUND_NOISE_EN
    if (noise_step) phase_d[0] = lfsr_nx[0];
`endif
  end

  always_comb begin
    mix_d = '0;
    for (int c = 0; c < CHANNELS; c++)
      mix_d = mix_d + MW'(contrib[c]);
  end

  // Contribution is registered so writes reach mix two edges later and snd three.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c]     <= 8'd0;
        contrib[c] <= 8'd0;
      end
      phase <= '0;
      mix   <= '0;
      acc   <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c]     <= cnt_d[c];
        contrib[c] <= phase_d[c] ? level[c] : 8'd0;
      end
      phase <= phase_d;
      mix   <= mix_d;
      acc   <= {1'b0, acc[MW-1:0]} + (MW + 1)'(mix);
    end
  end

  assign snd = acc[MW];

endmodule

// File: tb/tb_sound_mix.sv
// Randomized self-checking bench for sound_mix: two instances (PRESCALE 1 and 5)
// compared against a behavioural model plus fixed density expectations.
module tb_sound_mix;

  localparam int PS0 = 1;
  localparam int PS1 = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] data_in = 8'd0;
  logic       wr = 1'b0;
  logic       snd0, snd1;

  int total = 0;
  int bad = 0;

  sound_mix #(.CHANNELS(2), .ADDR_W(3), .PRESCALE(PS0)) u0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .wr(wr), .snd(snd0));
  sound_mix #(.CHANNELS(2), .ADDR_W(3), .PRESCALE(PS1)) u1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .wr(wr), .snd(snd1));

  always #5 clk = ~clk;

  // Reference: registers shared by both instances, tone/mix state per instance.
  int m_period[2], m_level[2], m_ctl;
  int m_ticks_left[2][2], m_high[2][2], m_contrib[2][2];
  int m_pre[2], m_mix[2], m_acc[2];
  bit exp_snd[2];

  task automatic model_reset();
    m_ctl = 0;
    for (int c = 0; c < 2; c++) begin
      m_period[c] = 0;
      m_level[c] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        m_ticks_left[k][c] = 0;
        m_high[k][c] = 0;
        m_contrib[k][c] = 0;
      end
      m_pre[k] = 0;
      m_mix[k] = 0;
      m_acc[k] = 0;
      exp_snd[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int ps, acc_n, mix_n;
    bit tick;
    ps = (k == 0) ? PS0 : PS1;
    tick = (m_pre[k] == ps - 1);
    acc_n = (m_acc[k] % 512) + m_mix[k];
    mix_n = m_contrib[k][0] + m_contrib[k][1];
    for (int c = 0; c < 2; c++) begin
      if (((m_ctl >> c) & 1) == 0) begin
        m_ticks_left[k][c] = 0;
        m_high[k][c] = 0;
      end else if (m_period[c] == 0) begin
        m_ticks_left[k][c] = 0;
        m_high[k][c] = 1;
      end else if (tick) begin
        if (m_ticks_left[k][c] == 0) begin
          m_ticks_left[k][c] = m_period[c] - 1;
          m_high[k][c] = 1 - m_high[k][c];
        end else begin
          m_ticks_left[k][c] = m_ticks_left[k][c] - 1;
        end
      end
      m_contrib[k][c] = m_high[k][c] ? m_level[c] : 0;
    end
    m_pre[k] = tick ? 0 : m_pre[k] + 1;
    m_mix[k] = mix_n;
    m_acc[k] = acc_n;
    exp_snd[k] = (acc_n >= 512);
  endtask

  task automatic model_write();
    if (wr) begin
      if (addr < 4) begin
        if (addr[0]) m_level[addr >> 1] = int'(data_in);
        else         m_period[addr >> 1] = int'(data_in);
      end else if (addr == 3'd4) begin
        m_ctl = int'(data_in);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    model_write();
    @(negedge clk);
  endtask

  task automatic wr_reg(input int a, input int d);
    addr = 3'(a);
    data_in = 8'(d);
    wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    total += 2;
    if (snd0 !== 1'b0) begin bad++; $display("FAIL reset_u0: snd=%0b expected 0", snd0); end
    if (snd1 !== 1'b0) begin bad++; $display("FAIL reset_u1: snd=%0b expected 0", snd1); end
    rst_n = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      cyc();
      total += 2;
      if (snd0 !== 1'b0) begin bad++; $display("FAIL idle_u0 cyc %0d: snd=%0b expected 0", n, snd0); end
      if (snd1 !== 1'b0) begin bad++; $display("FAIL idle_u1 cyc %0d: snd=%0b expected 0", n, snd1); end
    end
  endtask

  task automatic test_dc();
    int ones0, ones1;
    wr_reg(0, 0);
    wr_reg(1, 128);
    wr_reg(4, 8'h01);
    for (int n = 0; n < 20; n++) begin
      cyc();
      total += 2;
      if (snd0 !== exp_snd[0]) begin bad++; $display("FAIL dc_model_u0 cyc %0d: snd=%0b expected %0b", n, snd0, exp_snd[0]); end
      if (snd1 !== exp_snd[1]) begin bad++; $display("FAIL dc_model_u1 cyc %0d: snd=%0b expected %0b", n, snd1, exp_snd[1]); end
    end
    for (int w = 0; w < 2; w++) begin
      ones0 = 0;
      ones1 = 0;
      for (int n = 0; n < 512; n++) begin
        cyc();
        ones0 += int'(snd0);
        ones1 += int'(snd1);
      end
      total += 2;
      if (ones0 != 128) begin bad++; $display("FAIL dc_window_u0 %0d: ones=%0d expected 128", w, ones0); end
      if (ones1 != 128) begin bad++; $display("FAIL dc_window_u1 %0d: ones=%0d expected 128", w, ones1); end
    end
  endtask

  task automatic test_full_scale();
    int ones0, ones1;
    wr_reg(0, 0);
    wr_reg(2, 0);
    wr_reg(1, 255);
    wr_reg(3, 255);
    wr_reg(4, 8'h03);
    repeat (20) cyc();
    ones0 = 0;
    ones1 = 0;
    for (int n = 0; n < 512; n++) begin
      cyc();
      ones0 += int'(snd0);
      ones1 += int'(snd1);
    end
    total += 2;
    if (ones0 != 510) begin bad++; $display("FAIL full_window_u0: ones=%0d expected 510", ones0); end
    if (ones1 != 510) begin bad++; $display("FAIL full_window_u1: ones=%0d expected 510", ones1); end
    wr_reg(4, 8'h00);
    cyc();
    cyc();
    for (int n = 0; n < 40; n++) begin
      cyc();
      total += 2;
      if (snd0 !== 1'b0) begin bad++; $display("FAIL mute_u0 N+%0d: snd=%0b expected 0", n + 3, snd0); end
      if (snd1 !== 1'b0) begin bad++; $display("FAIL mute_u1 N+%0d: snd=%0b expected 0", n + 3, snd1); end
    end
  endtask

  task automatic test_tone();
    wr_reg(0, 4);
    wr_reg(1, 255);
    wr_reg(4, 8'h01);
    for (int n = 0; n < 100; n++) begin
      if (n == 37) begin
        addr = 3'd0; data_in = 8'd8; wr = 1'b1;
      end else begin
        wr = 1'b0;
      end
      cyc();
      total += 2;
      if (snd0 !== exp_snd[0]) begin bad++; $display("FAIL tone_u0 cyc %0d: snd=%0b expected %0b", n, snd0, exp_snd[0]); end
      if (snd1 !== exp_snd[1]) begin bad++; $display("FAIL tone_u1 cyc %0d: snd=%0b expected %0b", n, snd1, exp_snd[1]); end
    end
    wr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ones0;
    int seq_a[5] = '{1, 3, 0, 2, 4};
    int seq_d[5] = '{200, 100, 0, 0, 3};
    for (int n = 0; n < 35; n++) begin
      if (n < 5) begin
        addr = 3'(seq_a[n]); data_in = 8'(seq_d[n]); wr = 1'b1;
      end else begin
        wr = 1'b0;
      end
      cyc();
      total += 2;
      if (snd0 !== exp_snd[0]) begin bad++; $display("FAIL b2b_u0 cyc %0d: snd=%0b expected %0b", n, snd0, exp_snd[0]); end
      if (snd1 !== exp_snd[1]) begin bad++; $display("FAIL b2b_u1 cyc %0d: snd=%0b expected %0b", n, snd1, exp_snd[1]); end
    end
    ones0 = 0;
    for (int n = 0; n < 512; n++) begin
      cyc();
      ones0 += int'(snd0);
    end
    total++;
    if (ones0 != 300) begin bad++; $display("FAIL b2b_window: ones=%0d expected 300", ones0); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      wr = ($urandom_range(0, 3) == 0);
      addr = 3'($urandom_range(0, 7));
      if (addr < 4 && !addr[0]) data_in = 8'($urandom_range(0, 6));
      else                      data_in = 8'($urandom);
      cyc();
      total += 2;
      if (snd0 !== exp_snd[0]) begin bad++; $display("FAIL rand_u0 cyc %0d: snd=%0b expected %0b", n, snd0, exp_snd[0]); end
      if (snd1 !== exp_snd[1]) begin bad++; $display("FAIL rand_u1 cyc %0d: snd=%0b expected %0b", n, snd1, exp_snd[1]); end
    end
    wr = 1'b0;
  endtask

  task automatic test_async_reset();
    wr_reg(0, 3);
    wr_reg(1, 255);
    wr_reg(2, 0);
    wr_reg(3, 90);
    wr_reg(4, 8'h03);
    repeat (50) cyc();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total += 5;
    if (snd0 !== 1'b0) begin bad++; $display("FAIL areset_snd_u0: snd=%0b expected 0", snd0); end
    if (snd1 !== 1'b0) begin bad++; $display("FAIL areset_snd_u1: snd=%0b expected 0", snd1); end
    if (u0.mix !== '0) begin bad++; $display("FAIL areset_mix_u0: mix=%0d expected 0", u0.mix); end
    if (u0.acc !== '0) begin bad++; $display("FAIL areset_acc_u0: acc=%0d expected 0", u0.acc); end
    if (u1.mix !== '0) begin bad++; $display("FAIL areset_mix_u1: mix=%0d expected 0", u1.mix); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 300; n++) begin
      cyc();
      total += 2;
      if (snd0 !== 1'b0) begin bad++; $display("FAIL post_reset_u0 cyc %0d: snd=%0b expected 0", n, snd0); end
      if (snd1 !== 1'b0) begin bad++; $display("FAIL post_reset_u1 cyc %0d: snd=%0b expected 0", n, snd1); end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_full_scale();
    test_tone();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
